ntt_pointwise_mul_4: RTL and testbench



---
 rtl/ntt_pkg.sv | 31 +++
 rtl/mod_mul_q.sv | 34 +++
 rtl/ntt_pointwise_mul_4.sv | 77 +++++++
 tb/tb_ntt_pointwise_mul_4.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT-domain constants, coefficient/vector types and packing helpers.
// Pure declarations: no latency, no flow control.
package ntt_pkg;

    localparam int W = 9;
    localparam int N = 4;
    localparam int Q = 257;
    // floor(2^(2W)/Q), the Barrett multiplier for the 2W-bit products
    localparam int BARRETT_MU = (1 << (2 * W)) / Q;

    typedef logic [W-1:0]   coeff_t;
    typedef logic [N*W-1:0] vec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    function automatic coeff_t get_coeff(input vec_t v, input int i);
        return v[i*W +: W];
    endfunction

    function automatic vec_t set_coeff(input vec_t v, input int i, input coeff_t c);
        vec_t r;
        r = v;
        r[i*W +: W] = c;
        return r;
    endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Combinational r = (a*b) mod Q by Barrett reduction; zero latency, no flow control.
// Operands may be unreduced W-bit values; the result is always below Q.
module mod_mul_q
    import ntt_pkg::*;
(
    input  coeff_t a,
    input  coeff_t b,
    output coeff_t r
);

    localparam int PW = 2 * W;
    localparam int MW = $clog2(BARRETT_MU + 1);

    logic [PW-1:0]    prod;
    logic [PW+MW-1:0] prod_mu;
    logic [MW-1:0]    q_est;
    logic [PW-1:0]    q_mul;
    logic [PW-1:0]    rem0;
    logic [PW-1:0]    rem1;
    logic [PW-1:0]    rem2;

    always_comb begin
        prod    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        prod_mu = {{MW{1'b0}}, prod} * (PW+MW)'(BARRETT_MU);
        q_est   = MW'(prod_mu >> PW);
        q_mul   = {{(PW-MW){1'b0}}, q_est} * PW'(Q);
        rem0    = prod - q_mul;
        // The quotient estimate undershoots by at most two, so two corrections suffice.
        rem1    = (rem0 >= PW'(Q)) ? rem0 - PW'(Q) : rem0;
        rem2    = (rem1 >= PW'(Q)) ? rem1 - PW'(Q) : rem1;
        r       = W'(rem2);
    end

endmodule

// File: rtl/ntt_pointwise_mul_4.sv
// Coefficient-wise (a[i]*b[i]) mod Q over one shared multiplier; out_valid N+1 cycles after accept.
// Accepts only in IDLE; the result is held in DONE until out_ready, so II is at least N+2.
module ntt_pointwise_mul_4
    import ntt_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N*W-1:0] a_hat,
    input  logic [N*W-1:0] b_hat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N*W-1:0] c_hat
);

    localparam int IW = $clog2(N);

    mul_state_t    state;
    mul_state_t    state_nxt;
    logic [IW-1:0] idx;
    vec_t          a_reg;
    vec_t          b_reg;
    vec_t          c_reg;
    coeff_t        a_cur;
    coeff_t        b_cur;
    coeff_t        prod_mod;

    assign a_cur     = get_coeff(a_reg, int'(idx));
    assign b_cur     = get_coeff(b_reg, int'(idx));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign c_hat     = c_reg;

    mod_mul_q u_mod_mul_q (
        .a (a_cur),
        .b (b_cur),
        .r (prod_mod)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = MUL;
            MUL:     if (idx == IW'(N - 1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a_hat;
                        b_reg <= b_hat;
                        idx   <= '0;
                    end
                end
                MUL: begin
                    c_reg <= set_coeff(c_reg, int'(idx), prod_mod);
                    idx   <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_pointwise_mul_4.sv
// Randomized and directed bench for ntt_pointwise_mul_4 against an arithmetic reference model.
module tb_ntt_pointwise_mul_4;

    localparam int CW = 9;
    localparam int CN = 4;
    localparam int CQ = 257;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CN*CW-1:0]  a_hat = '0;
    logic [CN*CW-1:0]  b_hat = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CN*CW-1:0]  c_hat;

    logic [CW-1:0]     sw_a = '0;
    logic [CW-1:0]     sw_b = '0;
    logic [CW-1:0]     sw_r;

    int n_checks = 0;
    int n_fails  = 0;
    logic [CN*CW-1:0] exp_q[$];

    always #5 clk = ~clk;

    ntt_pointwise_mul_4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_hat     (a_hat),
        .b_hat     (b_hat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_hat     (c_hat)
    );

    mod_mul_q u_sweep (
        .a (sw_a),
        .b (sw_b),
        .r (sw_r)
    );

    task automatic check(input string tag, input logic [CN*CW-1:0] obs, input logic [CN*CW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [CN*CW-1:0] model(input logic [CN*CW-1:0] a, input logic [CN*CW-1:0] b);
        logic [CN*CW-1:0] r;
        r = '0;
        for (int i = 0; i < CN; i++)
            r[i*CW +: CW] = CW'((int'(a[i*CW +: CW]) * int'(b[i*CW +: CW])) % CQ);
        return r;
    endfunction

    function automatic logic [CN*CW-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[CN*CW-1:0];
    endfunction

    // Waits for acceptance, then measures cycles to out_valid and retires the result.
    task automatic run_op(input string tag, input logic [CN*CW-1:0] a, input logic [CN*CW-1:0] b,
                          input logic [CN*CW-1:0] exp);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; a_hat = a; b_hat = b; out_ready = 1'b0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, "_accept_to"}, 36'(cyc >= 50), 36'd0);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 30) begin @(negedge clk); cyc++; end
        check({tag, "_latency"}, 36'(cyc), 36'd5);
        check({tag, "_c_hat"}, c_hat, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 36'(out_valid), 36'd0);
    endtask

    initial begin
        int errs;
        int cyc;
        int got;
        int hi;
        logic [CN*CW-1:0] held;
        logic [CN*CW-1:0] nxt_a;
        logic [CN*CW-1:0] nxt_b;
        logic [CN*CW-1:0] e;

        // Exhaustive sweep of the shared reducer.
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            for (int j = 0; j < 512; j++) begin
                sw_a = CW'(i); sw_b = CW'(j);
                #1;
                if (int'(sw_r) != (i * j) % CQ) errs++;
            end
        end
        check("mod_mul_sweep_errors", 36'(errs), 36'd0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 36'(in_ready), 36'd1);
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_c_hat", c_hat, 36'd0);

        run_op("basic", 36'h008040201, 36'h28100602, 36'h28100602);
        run_op("wrap", {4{9'd256}}, {4{9'd256}}, 36'h008040201);
        run_op("unreduced", {4{9'd511}}, {4{9'd511}}, {4{9'd9}});

        // Backpressure: DONE holds while new operands are offered.
        a_hat = rand_vec(); b_hat = rand_vec();
        e = model(a_hat, b_hat);
        @(negedge clk);
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        nxt_a = rand_vec(); nxt_b = rand_vec();
        a_hat = nxt_a; b_hat = nxt_b;
        cyc = 0;
        while (!out_valid && cyc < 30) begin @(negedge clk); cyc++; end
        check("bp_first_result", c_hat, e);
        held = c_hat;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_c_hat_stable", c_hat, held);
            check("bp_in_ready_low", 36'(in_ready), 36'd0);
            check("bp_out_valid_high", 36'(out_valid), 36'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", 36'(in_ready), 36'd1);
        check("bp_c_hat_kept", c_hat, held);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 30) begin @(negedge clk); cyc++; end
        check("bp_second_latency", 36'(cyc), 36'd5);
        check("bp_second_result", c_hat, model(nxt_a, nxt_b));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset during the second MUL cycle.
        @(negedge clk);
        in_valid = 1'b1; a_hat = rand_vec(); b_hat = rand_vec();
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_c_hat", c_hat, 36'd0);
        check("rstmid_out_valid", 36'(out_valid), 36'd0);
        check("rstmid_in_ready", 36'(in_ready), 36'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        hi = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) hi++;
        end
        out_ready = 1'b0;
        check("rstmid_no_spurious", 36'(hi), 36'd0);

        // Back-to-back random traffic with random downstream stalls.
        got = 0;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    logic [CN*CW-1:0] ra;
                    logic [CN*CW-1:0] rb;
                    int t;
                    ra = rand_vec(); rb = rand_vec();
                    @(negedge clk);
                    in_valid = 1'b1; a_hat = ra; b_hat = rb;
                    t = 0;
                    while (!in_ready && t < 100) begin @(negedge clk); t++; end
                    if (t >= 100) check("rand_accept_timeout", 36'(t), 36'd0);
                    exp_q.push_back(model(ra, rb));
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (got < 20 && t < 4000) begin
                    @(negedge clk);
                    t++;
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_output", 36'd1, 36'd0);
                        end else begin
                            check("rand_c_hat", c_hat, exp_q.pop_front());
                        end
                        for (int i = 0; i < CN; i++)
                            check("rand_coeff_lt_q", 36'(int'(c_hat[i*CW +: CW]) < CQ), 36'd1);
                        got++;
                    end
                end
                out_ready = 1'b0;
            end
        join
        check("rand_output_count", 36'(got), 36'd20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
